// File: rtl/toggle_pkg.sv
// rtl/toggle_pkg.sv - shared types and constants for the toggle link
// Purpose: receiver state enum and the default sync byte, also used by the
// toggle transmitter so both ends agree on framing.
// Ports: none (package).
package toggle_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      DATA = 1'b1
   } rx_state_t;

   localparam logic [7:0] TOGGLE_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/toggle_rx_if.sv
// rtl/toggle_rx_if.sv - line-side and byte-side signal bundle of the toggle receiver
// Purpose: groups the serial line input and the byte handshake of toggle_rx.
// Ports (signals):
//   din, din_valid   toggle-encoded line level and its per-cycle qualifier
//   data_out         received byte
//   data_valid       data_out holds an unconsumed byte
//   data_ready       consumer accepts data_out together with data_valid
//   sync_lock        high while inside a frame
//   overrun          one-cycle pulse when a completed byte is dropped
// Modports: master = line driver / byte consumer side, slave = receiver side.
interface toggle_rx_if;
   import toggle_pkg::*;

   logic       din;
   logic       din_valid;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       sync_lock;
   logic       overrun;

   modport master (
      output din, din_valid, data_ready,
      input  data_out, data_valid, sync_lock, overrun
   );

   modport slave (
      input  din, din_valid, data_ready,
      output data_out, data_valid, sync_lock, overrun
   );

endinterface

// File: rtl/toggle_bit_dec.sv
// rtl/toggle_bit_dec.sv - toggle line decoder: line change = 1, line hold = 0
// Purpose: remembers the last qualified line level and emits one decoded bit
// per qualified cycle.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   i_din          line level
//   i_din_valid    qualifies i_din for this cycle
//   o_bit          decoded bit (valid only with o_strobe)
//   o_strobe       one decoded bit is present this cycle
module toggle_bit_dec (
   input  logic clock,
   input  logic reset,
   input  logic i_din,
   input  logic i_din_valid,
   output logic o_bit,
   output logic o_strobe
);

   // Reset level 0 matches the transmitter's T flip-flop reset level.
   logic r_level;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_level <= 1'b0;
      end else if (i_din_valid) begin
         r_level <= i_din;
      end
   end

   assign o_bit    = i_din ^ r_level;
   assign o_strobe = i_din_valid;

endmodule

// File: rtl/toggle_rx.sv
// rtl/toggle_rx.sv - toggle-encoded serial receiver with sliding sync and byte framing
// Purpose: hunts for SYNC_WORD at any bit alignment, then delivers FRAME_BYTES
// LSB-first bytes over a valid/ready output, flagging bytes that arrive while
// the previous one is still unconsumed.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   bus            toggle_rx_if.slave (din/din_valid in, byte handshake out)
module toggle_rx
   import toggle_pkg::*;
#(
   parameter int         FRAME_BYTES = 4,
   parameter logic [7:0] SYNC_WORD   = TOGGLE_SYNC_WORD
) (
   input  logic          clock,
   input  logic          reset,
   toggle_rx_if.slave    bus
);

   logic       w_bit;
   logic       w_strobe;
   logic [7:0] w_shift_next;
   logic       w_sync_hit;
   logic       w_byte_done;
   logic       w_frame_done;
   rx_state_t  w_state_next;

   rx_state_t  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_byte_cnt;
   logic [7:0] r_data_out;
   logic       r_data_valid;
   logic       r_overrun;

   toggle_bit_dec u_bit_dec (
      .clock       (clock),
      .reset       (reset),
      .i_din       (bus.din),
      .i_din_valid (bus.din_valid),
      .o_bit       (w_bit),
      .o_strobe    (w_strobe)
   );

   // Shift register as it will look after this bit; both the sync compare
   // and the completed byte come from here so neither costs a cycle.
   assign w_shift_next = {w_bit, r_shift[7:1]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sync_hit   = 1'b0;
      w_byte_done  = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         HUNT: begin
            if (w_strobe && (w_shift_next == SYNC_WORD)) begin
               w_sync_hit   = 1'b1;
               w_state_next = DATA;
            end
         end
         DATA: begin
            if (w_strobe && (r_bit_cnt == 3'd7)) begin
               w_byte_done = 1'b1;
               if (r_byte_cnt == 8'(FRAME_BYTES - 1)) begin
                  w_frame_done = 1'b1;
                  w_state_next = HUNT;
               end
            end
         end
         default: w_state_next = HUNT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_byte_cnt   <= 8'd0;
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;

         // Clearing the shift register at frame end stops the tail of the
         // last byte from combining with new bits into a false sync.
         if (w_strobe) begin
            r_shift <= w_frame_done ? 8'h00 : w_shift_next;
         end

         if (w_sync_hit) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 8'd0;
         end else if (w_strobe && (r_state == DATA)) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
               r_byte_cnt <= r_byte_cnt + 8'd1;
            end
         end

         // A fresh byte wins over the clear from an accepted transfer.
         if (w_byte_done) begin
            if (!r_data_valid || bus.data_ready) begin
               r_data_out   <= w_shift_next;
               r_data_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_data_valid && bus.data_ready) begin
            r_data_valid <= 1'b0;
         end
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;
   assign bus.sync_lock  = (r_state == DATA);
   assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_toggle_rx.sv
// tb/tb_toggle_rx.sv - self-checking bench for toggle_rx
module tb_toggle_rx;
   import toggle_pkg::*;

   localparam int FB = 4;

   typedef struct {
      int          npre;
      logic [15:0] pre;
      logic [31:0] dat;
      bit          gap;
      int          nexp;
      logic [31:0] exp_bytes;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   toggle_rx_if bus ();

   toggle_rx #(.FRAME_BYTES(FB), .SYNC_WORD(TOGGLE_SYNC_WORD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: line level, 8-bit history window, frame bit counter.
   bit         m_level;
   int         m_win;
   bit         m_locked;
   int         m_bits;
   logic [7:0] m_out;
   bit         m_valid;
   bit         m_ovr;

   bit         tx_lvl;
   logic [7:0] got[$];
   bit         g_rdy;
   bit         g_rand_rdy;
   bit         g_gap;
   int         ovr_seen;
   vec_t       vecs[4];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(string name);
      check({name, ".data_out"},   32'(bus.data_out),   32'(m_out));
      check({name, ".data_valid"}, 32'(bus.data_valid), 32'(m_valid));
      check({name, ".sync_lock"},  32'(bus.sync_lock),  32'(m_locked));
      check({name, ".overrun"},    32'(bus.overrun),    32'(m_ovr));
   endtask

   task automatic model_reset();
      m_level = 0; m_win = 0; m_locked = 0; m_bits = 0;
      m_out = 8'h00; m_valid = 0; m_ovr = 0;
   endtask

   task automatic model_step(bit din, bit dv, bit rdy);
      int d;
      int nw;
      bit nv;
      bit no;
      nv = m_valid;
      no = 0;
      if (m_valid && rdy) nv = 0;
      if (dv) begin
         d = int'(din ^ m_level);
         m_level = din;
         nw = (m_win >> 1) + d * 128;
         m_win = nw;
         if (!m_locked) begin
            if (nw == int'(TOGGLE_SYNC_WORD)) begin
               m_locked = 1;
               m_bits = 0;
            end
         end else begin
            m_bits++;
            if (m_bits % 8 == 0) begin
               if (!m_valid || rdy) begin
                  m_out = nw[7:0];
                  nv = 1;
               end else begin
                  no = 1;
               end
               if (m_bits == 8 * FB) begin
                  m_locked = 0;
                  m_win = 0;
               end
            end
         end
      end
      m_valid = nv;
      m_ovr = no;
   endtask

   task automatic cycle(bit din, bit dv);
      bit rdy;
      rdy = g_rand_rdy ? bit'($urandom_range(0, 1)) : g_rdy;
      bus.din = din;
      bus.din_valid = dv;
      bus.data_ready = rdy;
      if (dv) tx_lvl = din;
      if (bus.data_valid && rdy) got.push_back(bus.data_out);
      model_step(din, dv, rdy);
      @(posedge clock);
      @(negedge clock);
      if (bus.overrun) ovr_seen++;
      check_outputs("cyc");
   endtask

   task automatic send_bit(bit b);
      cycle(tx_lvl ^ b, 1'b1);
      if (g_gap) cycle(bit'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic send_byte(logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(tx_lvl, 1'b0);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      tx_lvl = 0;
      check_outputs("rst_async");
      for (int i = 0; i < 2; i++) begin
         bus.din = bit'($urandom_range(0, 1));
         bus.din_valid = bit'($urandom_range(0, 1));
         bus.data_ready = bit'($urandom_range(0, 1));
         @(posedge clock);
         @(negedge clock);
         check_outputs("rst_hold");
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.din = 0;
      bus.din_valid = 0;
      bus.data_ready = 0;
      g_rdy = 1; g_rand_rdy = 0; g_gap = 0; ovr_seen = 0;
      model_reset();
      tx_lvl = 0;
      @(negedge clock);
      do_reset();

      // Table-driven frames, ready held high.
      vecs[0] = '{0, 16'h0000, 32'h81FF003C, 1'b0, 4, 32'h81FF003C};
      vecs[1] = '{2, 16'hFF5A, 32'h81FF003C, 1'b0, 4, 32'h81FF003C};
      vecs[2] = '{0, 16'h0000, 32'h81FF003C, 1'b1, 4, 32'h81FF003C};
      vecs[3] = '{0, 16'h0000, 32'hC35AA500, 1'b0, 4, 32'hC35AA500};
      for (int v = 0; v < 4; v++) begin
         logic [15:0] pre;
         logic [31:0] dat;
         logic [31:0] ex;
         pre = vecs[v].pre;
         dat = vecs[v].dat;
         ex  = vecs[v].exp_bytes;
         got.delete();
         g_rdy = 1;
         g_gap = vecs[v].gap;
         for (int p = 0; p < vecs[v].npre; p++) send_byte(pre[p*8 +: 8]);
         send_byte(TOGGLE_SYNC_WORD);
         for (int k = 0; k < 4; k++) send_byte(dat[k*8 +: 8]);
         g_gap = 0;
         idle(3);
         check($sformatf("vec%0d.count", v), 32'(got.size()), 32'(vecs[v].nexp));
         for (int k = 0; k < vecs[v].nexp && k < got.size(); k++)
            check($sformatf("vec%0d.byte%0d", v, k), 32'(got[k]), 32'(ex[k*8 +: 8]));
         check($sformatf("vec%0d.unlocked", v), 32'(bus.sync_lock), 32'd0);
      end

      // Lock appears exactly one cycle after the final sync bit.
      do_reset();
      begin
         logic [7:0] sw;
         sw = TOGGLE_SYNC_WORD;
         g_rdy = 1;
         send_byte(8'h5A);
         send_byte(8'hFF);
         check("pre.lock", 32'(bus.sync_lock), 32'd0);
         for (int i = 0; i < 7; i++) send_bit(sw[i]);
         check("sync7.lock", 32'(bus.sync_lock), 32'd0);
         send_bit(sw[7]);
         check("sync8.lock", 32'(bus.sync_lock), 32'd1);
         for (int k = 0; k < FB; k++) send_byte(8'h12 + 8'(k));
         idle(2);
      end

      // Consumer stalled across bytes 1 and 2.
      do_reset();
      got.delete();
      ovr_seen = 0;
      g_rdy = 0;
      send_byte(TOGGLE_SYNC_WORD);
      send_byte(8'h3C);
      send_byte(8'h00);
      check("stall.data_out", 32'(bus.data_out), 32'h3C);
      check("stall.valid", 32'(bus.data_valid), 32'd1);
      check("stall.overruns", 32'(ovr_seen), 32'd1);
      g_rdy = 1;
      idle(3);
      check("stall.count", 32'(got.size()), 32'd1);
      if (got.size() > 0) check("stall.byte", 32'(got[0]), 32'h3C);

      // Reset in the middle of byte 2, then data without sync, then a new frame.
      do_reset();
      g_rdy = 1;
      send_byte(TOGGLE_SYNC_WORD);
      send_byte(8'h3C);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      do_reset();
      got.delete();
      send_byte(8'h3C);
      send_byte(8'h00);
      idle(2);
      check("nosync.count", 32'(got.size()), 32'd0);
      send_byte(TOGGLE_SYNC_WORD);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      idle(2);
      check("resync.count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         check($sformatf("resync.byte%0d", k), 32'(got[k]), 32'h11 * (k + 1));

      // Randomized traffic: noise, random gaps and random consumer stalls.
      do_reset();
      g_rand_rdy = 1;
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++)
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            g_gap = bit'($urandom_range(0, 1));
            send_byte(TOGGLE_SYNC_WORD);
            for (int k = 0; k < FB; k++) send_byte(8'($urandom_range(0, 255)));
            g_gap = 0;
         end
      end
      g_rand_rdy = 0;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001: Parameter FRAME_BYTES, default 4, number of data bytes per frame after sync (range 1..255).
REQ-002: Parameter SYNC_WORD, default 8'hA5, decoded sync byte that opens a frame.
REQ-003: clock  input  1  single clock for all state; rising-edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: din  input  1  toggle-encoded line level from a T-flip-flop transmitter; line toggles = bit 1, line holds = bit 0.
REQ-006: din_valid  input  1  qualifies din for one bit per cycle it is high.
REQ-007: data_out  output  8  received byte.
REQ-008: data_valid  output  1  data_out holds an unconsumed byte.
REQ-009: data_ready  input  1  consumer accepts data_out when high together with data_valid.
REQ-010: sync_lock  output  1  high while inside a frame (DATA state).
REQ-011: overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-012: Decoded bit d = din XOR level_q, evaluated only when din_valid=1; level_q loads din on every din_valid cycle; level_q reset value 0, matching the transmitter's reset level.
REQ-013: Bits are serial LSB-first; shift_q updates as {d, shift_q[7:1]} on each valid bit.
REQ-014: States: HUNT, DATA; reset state HUNT.
REQ-015: HUNT: on a valid bit where {d, shift_q[7:1]} == SYNC_WORD -> DATA, bit_cnt=0, byte_cnt=0; sync_lock high from the next cycle; sync match is sliding (any bit alignment).
REQ-016: DATA: bit_cnt increments per valid bit, wraps 7->0; on the valid bit with bit_cnt==7 the byte {d, shift_q[7:1]} is complete.
REQ-017: Byte completion with data_valid=0, or data_valid=1 and data_ready=1 the same cycle: data_out loads, data_valid=1 the next cycle (latency 1 cycle after 8th bit sampled).
REQ-018: Byte completion with data_valid=1 and data_ready=0: byte discarded, data_out unchanged, overrun=1 for exactly the next cycle; byte still counts toward FRAME_BYTES.
REQ-019: data_valid clears the cycle after a valid&&ready transfer unless a new byte loads that same cycle (REQ-017 takes priority).
REQ-020: After the FRAME_BYTES-th byte completes -> HUNT, shift_q cleared to 0, sync_lock low next cycle; a pending data_valid byte stays held until accepted.
REQ-021: din_valid=0 cycles: no change to level_q, shift_q, counters or state; gaps of any length allowed.
REQ-022: data_ready while data_valid=0 has no effect.

Reset
REQ-023: Asserting reset immediately clears level_q, shift_q, bit_cnt, byte_cnt, data_out=8'h00, data_valid=0, sync_lock=0, overrun=0, state=HUNT, including mid-frame.
REQ-024: After reset deasserts, a complete new SYNC_WORD is required before any byte is delivered.

Structure
REQ-025: Shared package toggle_pkg holds the state enum (HUNT, DATA) and the default SYNC_WORD constant 8'hA5, shared with the toggle transmitter.
REQ-026: One sub-module, toggle_bit_dec: holds level_q, outputs d and a bit strobe (din_valid); toggle_rx instantiates it once.

Verification
REQ-027: Reset asserted for 2 cycles with random din -> data_out=8'h00, data_valid=0, sync_lock=0, overrun=0 throughout.
REQ-028: Line encoding of A5, then 3C,00,FF,81, data_ready=1, din_valid=1 -> four bytes 3C,00,FF,81 each valid 1 cycle after its 8th bit; sync_lock falls after byte 81.
REQ-029: Preamble 5A,FF before A5 -> no lock during preamble; lock exactly 1 cycle after the A5 final bit.
REQ-030: data_ready=0 across bytes 1 and 2 -> data_out=3C held, second byte dropped, one overrun pulse; raising ready then delivers 3C only.
REQ-031: din_valid high every other cycle, same frame as REQ-028 -> identical byte sequence; no state change on idle cycles.
REQ-032: reset pulsed during byte 2 -> outputs cleared asynchronously; subsequent data without new sync yields no bytes; new A5 frame decodes correctly.
